interval_timer: RTL and testbench
=================================

Name: interval_timer

Overview:
- Consumer/reader side of the time-parameter store: requests an interval type, reads back the programmed 4-bit duration, and counts it down in seconds.
- Asserts a one-cycle expired pulse when the duration has elapsed.
- Sits between the traffic-light sequencing FSM, which issues start requests, and the time-parameter register block, which is driven through interval_sel and answers on value.
- Contains its own clock-to-seconds prescaler, so the FSM sees whole-second timing only.

Parameters:
- CLK_PER_SEC, 4, clock cycles per one-second tick (1 to 2^24; sim default 4).
- FETCH_CYCLES, 1, cycles between driving interval_sel and sampling value (1 to 3); covers the parameter block's registered-output latency.

Ports:
- clock  input  1  system clock; all logic rises on the posedge.
- reset_sync_n  input  1  synchronous, active-low reset.
- start_timer  input  1  single-cycle request to (re)start timing.
- req_interval  input  2  interval type: 00 base, 01 extended, 10 yellow; 11 is treated as 00.
- value  input  4  duration in seconds returned by the time-parameter block.
- interval_sel  output  2  interval selector driven to the time-parameter block.
- busy  output  1  high in FETCH and RUN.
- remaining  output  4  seconds left in the current interval.
- expired  output  1  one-cycle pulse at interval completion.

Behaviour:
- Reset (reset_sync_n=0 at an edge):
  - state=IDLE; interval_sel=00; remaining=0; expired=0; busy=0.
  - Prescaler and fetch counter cleared.
  - Reset overrides start_timer and can occur in any state.
- States: IDLE, FETCH, RUN, DONE.
- IDLE:
  - start_timer=1 at edge t: interval_sel <= req_interval (11 maps to 00); state <= FETCH; fetch counter <= 0.
- FETCH:
  - Stays FETCH_CYCLES cycles, then samples value at that edge.
  - remaining <= value; prescaler <= 0.
  - If value==0: go to DONE (zero-length interval still produces an expired pulse). Otherwise go to RUN.
- RUN:
  - Prescaler counts 0..CLK_PER_SEC-1. Tick = prescaler at CLK_PER_SEC-1; prescaler wraps to 0.
  - On tick: if remaining>1, remaining decrements. If remaining==1, remaining <= 0 and state <= DONE.
  - Time from the value-capture edge to DONE entry is exactly value*CLK_PER_SEC cycles.
- DONE:
  - expired=1 for exactly this one cycle.
  - Next state is IDLE, unless start_timer=1 in this cycle, in which case the next state is FETCH with a new interval_sel.
- expired is registered and asserted only in DONE; busy=1 only in FETCH and RUN.
- start_timer during FETCH or RUN aborts the current interval:
  - interval_sel reloads from req_interval; fetch counter cleared; state <= FETCH.
  - No expired pulse is issued for the aborted interval.
  - remaining holds its value until the new capture.
- Changes to value after capture (reprogramming of the parameter block) do not affect the running count.
- interval_sel is held stable from the request until the next request or reset.
- remaining never wraps below 0. The prescaler width is clog2(CLK_PER_SEC), minimum 1 bit.

Test Plan:
1. Reset: hold reset_sync_n=0 for 3 cycles with start_timer=1 -> state IDLE, busy=0, expired=0, remaining=0, interval_sel=00.
2. Base interval, CLK_PER_SEC=4, FETCH_CYCLES=1, value=5:
   - start with req_interval=00 -> interval_sel=00 the next cycle; remaining=5 after 1 fetch cycle.
   - remaining decrements every 4 cycles.
   - expired pulses exactly 20 cycles after capture, for 1 cycle; then busy=0.
3. Zero and reserved selects:
   - value=0, req_interval=10 -> expired pulses in the cycle after capture; remaining stays 0.
   - req_interval=11 -> interval_sel=00.
4. Abort:
   - start extended (value=9); after 10 cycles pulse start with req_interval=10 and value=3.
   - No expired pulse for the first interval; interval_sel=10; expired 12 cycles after the new capture.
5. Reprogram mid-run: change value from 7 to 2 during RUN -> remaining continues from the captured 7; expired after 28 cycles.
6. Reset mid-RUN with remaining=4 -> next cycle remaining=0, busy=0, no expired.
7. Back-to-back: start_timer asserted in the DONE cycle -> exactly one expired pulse, and FETCH is entered immediately.

Source files
------------

// File: rtl/interval_timer_if.sv
// Interval timer bus: start requests and parameter-block lookups in, timer status out.
// The master modport is the sequencing side; the slave modport is the timer.
interface interval_timer_if;
   logic       start_timer;
   logic [1:0] req_interval;
   logic [3:0] value;
   logic [1:0] interval_sel;
   logic       busy;
   logic [3:0] remaining;
   logic       expired;

   modport master (
      output start_timer,
      output req_interval,
      output value,
      input  interval_sel,
      input  busy,
      input  remaining,
      input  expired
   );

   modport slave (
      input  start_timer,
      input  req_interval,
      input  value,
      output interval_sel,
      output busy,
      output remaining,
      output expired
   );
endinterface

// File: rtl/interval_timer.sv
// Fetches an interval duration from the time-parameter block and counts it down in whole
// seconds, pulsing expired for one cycle when it elapses.
module interval_timer #(
   parameter int unsigned CLK_PER_SEC  = 4,
   parameter int unsigned FETCH_CYCLES = 1
) (
   input logic             clock,
   input logic             reset_sync_n,
   interval_timer_if.slave bus_io
);

   localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PrescLast = PW'(CLK_PER_SEC - 1);
   localparam logic [1:0] FetchLast = 2'(FETCH_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StRun, StDone} state_e;

   state_e        state_q, state_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    fetch_cnt_q, fetch_cnt_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    remaining_q, remaining_d;
   logic          expired_q;
   logic          busy_q;
   logic          tick;
   logic          fetch_done;
   logic [1:0]    req_sel;

   // Reserved selector 11 falls back to the base interval.
   assign req_sel    = (bus_io.req_interval == 2'b11) ? 2'b00 : bus_io.req_interval;
   assign tick       = (presc_q == PrescLast);
   assign fetch_done = (fetch_cnt_q == FetchLast);

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      fetch_cnt_d = fetch_cnt_q;
      presc_d     = presc_q;
      remaining_d = remaining_q;

      // A start request wins in every state, silently abandoning any interval in flight.
      if (bus_io.start_timer) begin
         state_d     = StFetch;
         sel_d       = req_sel;
         fetch_cnt_d = 2'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StFetch: begin
               if (fetch_done) begin
                  remaining_d = bus_io.value;
                  presc_d     = '0;
                  state_d     = (bus_io.value == 4'd0) ? StDone : StRun;
               end else begin
                  fetch_cnt_d = fetch_cnt_q + 2'd1;
               end
            end
            StRun: begin
               presc_d = tick ? '0 : presc_q + PW'(1);
               if (tick) begin
                  if (remaining_q > 4'd1) begin
                     remaining_d = remaining_q - 4'd1;
                  end else begin
                     remaining_d = 4'd0;
                     state_d     = StDone;
                  end
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_sync_n) begin
         state_q     <= StIdle;
         sel_q       <= 2'b00;
         fetch_cnt_q <= 2'd0;
         presc_q     <= '0;
         remaining_q <= 4'd0;
         expired_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         fetch_cnt_q <= fetch_cnt_d;
         presc_q     <= presc_d;
         remaining_q <= remaining_d;
         expired_q   <= (state_d == StDone);
         busy_q      <= (state_d == StFetch) || (state_d == StRun);
      end
   end

   assign bus_io.interval_sel = sel_q;
   assign bus_io.remaining    = remaining_q;
   assign bus_io.expired      = expired_q;
   assign bus_io.busy         = busy_q;

`ifndef SYNTHESIS
   a_exp_not_busy : assert property (@(posedge clock) disable iff (!reset_sync_n)
      expired_q |-> !busy_q);
   a_exp_single : assert property (@(posedge clock) disable iff (!reset_sync_n)
      expired_q |=> !expired_q);
   a_sel_legal : assert property (@(posedge clock) disable iff (!reset_sync_n)
      sel_q != 2'b11);
`endif

endmodule

// File: tb/tb_interval_timer.sv
// Directed and randomized bench for interval_timer, checked every cycle against an
// elapsed-time reference model.
module tb_interval_timer;
   localparam int Cps   = 4;
   localparam int Fetch = 1;

   logic clock = 1'b0;
   logic reset_sync_n;

   interval_timer_if tmr ();

   interval_timer #(
      .CLK_PER_SEC (Cps),
      .FETCH_CYCLES(Fetch)
   ) dut (
      .clock       (clock),
      .reset_sync_n(reset_sync_n),
      .bus_io      (tmr)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int exp_cnt  = 0;
   int last_exp_edge = -1;

   // Reference model: outputs derived from the capture edge and elapsed cycles.
   int m_sel, m_rem, m_exp, m_busy;
   int cap_edge, done_edge, cap_val;
   bit m_wait, m_count;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic model_step();
      edge_n++;
      if (!reset_sync_n) begin
         m_sel = 0; m_rem = 0; m_exp = 0; m_busy = 0;
         m_wait = 1'b0; m_count = 1'b0;
         return;
      end
      m_exp = 0;
      if (tmr.start_timer) begin
         m_sel    = (tmr.req_interval == 2'b11) ? 0 : int'(tmr.req_interval);
         m_wait   = 1'b1;
         m_count  = 1'b0;
         m_busy   = 1;
         cap_edge = edge_n + Fetch;
         return;
      end
      if (m_wait && edge_n == cap_edge) begin
         m_wait    = 1'b0;
         m_count   = 1'b1;
         cap_val   = int'(tmr.value);
         done_edge = edge_n + cap_val * Cps;
      end
      if (m_count) begin
         if (edge_n == done_edge) begin
            m_count = 1'b0;
            m_exp   = 1;
            m_busy  = 0;
            m_rem   = 0;
         end else begin
            m_rem = cap_val - (edge_n - cap_edge) / Cps;
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      check_eq("sel", 32'(tmr.interval_sel), m_sel);
      check_eq("remaining", 32'(tmr.remaining), m_rem);
      check_eq("busy", 32'(tmr.busy), m_busy);
      check_eq("expired", 32'(tmr.expired), m_exp);
      if (tmr.expired === 1'b1) begin
         exp_cnt++;
         last_exp_edge = edge_n;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_pulse(input logic [1:0] req, input logic [3:0] val, output int s);
      tmr.start_timer  = 1'b1;
      tmr.req_interval = req;
      tmr.value        = val;
      step();
      s = edge_n;
      tmr.start_timer = 1'b0;
   endtask

   initial begin
      int s, s2;
      bit found;

      reset_sync_n     = 1'b0;
      tmr.start_timer  = 1'b1;
      tmr.req_interval = 2'b10;
      tmr.value        = 4'd7;
      run(3);
      check_eq("rst_sel", 32'(tmr.interval_sel), 0);
      check_eq("rst_busy", 32'(tmr.busy), 0);
      check_eq("rst_rem", 32'(tmr.remaining), 0);
      check_eq("rst_exp", 32'(tmr.expired), 0);
      reset_sync_n    = 1'b1;
      tmr.start_timer = 1'b0;
      run(2);

      // Base interval of 5 s.
      exp_cnt = 0;
      start_pulse(2'b00, 4'd5, s);
      step();
      check_eq("base_cap", 32'(tmr.remaining), 5);
      run(24);
      check_eq("base_npulse", exp_cnt, 1);
      check_eq("base_time", last_exp_edge - s, 1 + 20);

      // Zero-length interval and reserved selector.
      exp_cnt = 0;
      start_pulse(2'b10, 4'd0, s);
      check_eq("zero_sel", 32'(tmr.interval_sel), 2);
      run(4);
      check_eq("zero_time", last_exp_edge - s, 1);
      check_eq("zero_npulse", exp_cnt, 1);
      start_pulse(2'b11, 4'd0, s);
      check_eq("rsvd_sel", 32'(tmr.interval_sel), 0);
      run(4);

      // Abort a running extended interval.
      exp_cnt = 0;
      start_pulse(2'b01, 4'd9, s);
      run(10);
      start_pulse(2'b10, 4'd3, s2);
      run(20);
      check_eq("abort_npulse", exp_cnt, 1);
      check_eq("abort_time", last_exp_edge - s2, 1 + 12);
      check_eq("abort_sel", 32'(tmr.interval_sel), 2);

      // Reprogramming the parameter block mid-run has no effect.
      exp_cnt = 0;
      start_pulse(2'b00, 4'd7, s);
      run(5);
      tmr.value = 4'd2;
      run(30);
      check_eq("reprog_npulse", exp_cnt, 1);
      check_eq("reprog_time", last_exp_edge - s, 1 + 28);

      // Reset while running.
      start_pulse(2'b00, 4'd5, s);
      run(5);
      check_eq("midrst_rem_before", 32'(tmr.remaining), 4);
      exp_cnt = 0;
      reset_sync_n = 1'b0;
      step();
      reset_sync_n = 1'b1;
      check_eq("midrst_rem", 32'(tmr.remaining), 0);
      check_eq("midrst_busy", 32'(tmr.busy), 0);
      run(25);
      check_eq("midrst_npulse", exp_cnt, 0);

      // Back-to-back: restart in the DONE cycle.
      exp_cnt = 0;
      start_pulse(2'b00, 4'd1, s);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = (tmr.expired === 1'b1);
      end
      check_eq("b2b_first_done", 32'(found), 1);
      start_pulse(2'b01, 4'd2, s);
      check_eq("b2b_busy", 32'(tmr.busy), 1);
      check_eq("b2b_exp", 32'(tmr.expired), 0);
      check_eq("b2b_sel", 32'(tmr.interval_sel), 1);
      run(15);
      check_eq("b2b_npulse", exp_cnt, 2);

      // Randomized traffic, including reprogramming, aborts and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         tmr.start_timer  = ($urandom_range(0, 24) == 0);
         tmr.req_interval = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) tmr.value = 4'($urandom_range(0, 6));
         reset_sync_n = ($urandom_range(0, 199) != 0);
         step();
      end
      reset_sync_n    = 1'b1;
      tmr.start_timer = 1'b0;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
